// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory bus between instruction fetch (IF) and load/store (MEM), one transaction at a time.
// Latency: at least 3 cycles from request to valid (arbitration, bus grant, bus response), plus any bus delay.
// Backpressure: a requester is stalled until its valid pulse; MEM priority is capped at MAX_MEM_RUN grants while IF waits.
module mem_port_arbiter #(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_MEM_RUN = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            flush,
    output logic            if_valid,
    output logic [DW-1:0]   if_rdata,
    input  logic            mem_req,
    input  logic            mem_we,
    input  logic [AW-1:0]   mem_addr,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [DW/8-1:0] mem_be,
    output logic            mem_valid,
    output logic [DW-1:0]   mem_rdata,
    output logic            stall_if,
    output logic            stall_mem,
    output logic            bus_err,
    output logic            bus_req,
    output logic            bus_we,
    output logic [AW-1:0]   bus_addr,
    output logic [DW-1:0]   bus_wdata,
    output logic [DW/8-1:0] bus_be,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [DW-1:0]   bus_rdata
);

    localparam int RW = $clog2(MAX_MEM_RUN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
    typedef enum logic {OWN_IF, OWN_MEM} owner_t;

    state_t        state;
    owner_t        owner;
    logic          drop;
    logic [RW-1:0] run_cnt;
    logic [TW-1:0] to_cnt;

    logic arb_en;
    logic mem_win;
    logic if_win;
    logic done;
    logic timed_out;
    logic if_flushed;

    // No grant during a valid pulse: the requester's signals still describe the request just completed.
    assign arb_en     = (state == ST_IDLE) && !if_valid && !mem_valid;
    assign mem_win    = mem_req && (!if_req || (run_cnt < RW'(MAX_MEM_RUN)));
    assign if_win     = !mem_win && if_req && !flush;
    assign timed_out  = (to_cnt == TW'(TIMEOUT));
    assign done       = (state == ST_WAIT) && (bus_rvalid || timed_out);
    assign if_flushed = drop || flush;

    assign bus_req   = (state == ST_REQ);
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = mem_req & ~mem_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            drop      <= 1'b0;
            run_cnt   <= '0;
            to_cnt    <= '0;
            if_valid  <= 1'b0;
            if_rdata  <= '0;
            mem_valid <= 1'b0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
        end else begin
            if_valid  <= 1'b0;
            mem_valid <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (arb_en) begin
                        if (if_win || !if_req) begin
                            run_cnt <= '0;
                        end else if (mem_win) begin
                            run_cnt <= run_cnt + RW'(1);
                        end
                        if (mem_win) begin
                            owner     <= OWN_MEM;
                            bus_we    <= mem_we;
                            bus_addr  <= mem_addr;
                            bus_wdata <= mem_wdata;
                            bus_be    <= mem_be;
                            state     <= ST_REQ;
                        end else if (if_win) begin
                            owner     <= OWN_IF;
                            bus_we    <= 1'b0;
                            bus_addr  <= if_addr;
                            bus_wdata <= '0;
                            bus_be    <= '1;
                            state     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (flush && owner == OWN_IF) begin
                        drop <= 1'b1;
                    end
                    if (bus_gnt) begin
                        state  <= ST_WAIT;
                        to_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (done) begin
                        state   <= ST_IDLE;
                        drop    <= 1'b0;
                        bus_err <= !bus_rvalid;
                        // A lost response completes with zero data so the requester is never left hanging.
                        if (owner == OWN_MEM) begin
                            mem_valid <= 1'b1;
                            if (!bus_we) begin
                                mem_rdata <= bus_rvalid ? bus_rdata : '0;
                            end
                        end else if (!if_flushed) begin
                            if_valid <= 1'b1;
                            if_rdata <= bus_rvalid ? bus_rdata : '0;
                        end
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                        if (flush && owner == OWN_IF) begin
                            drop <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each bus transaction with a request/grant/response handshake and allows one outstanding transaction at a time.
- Produces the stall_if and stall_mem signals consumed by the pipeline stall logic.
- Drops a fetch response after a branch flush, and bounds MEM priority so that fetch cannot starve.

Parameters:
- AW, 32, address width.
- DW, 32, data width; must be a multiple of 8.
- MAX_MEM_RUN, 4, maximum consecutive MEM grants while if_req is pending.
- TIMEOUT, 255, number of WAIT cycles before a response is declared lost.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high with if_addr stable until if_valid.
- if_addr  in  AW  fetch address.
- flush  in  1  branch-taken flush from the hazard logic.
- if_valid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DW  fetched instruction.
- mem_req  in  1  data request; held high with its fields stable until mem_valid.
- mem_we  in  1  1 = store.
- mem_addr  in  AW  data address.
- mem_wdata  in  DW  store data.
- mem_be  in  DW/8  byte enables.
- mem_valid  out  1  one-cycle pulse; load data or store acknowledge.
- mem_rdata  out  DW  load data.
- stall_if  out  1  IF must hold.
- stall_mem  out  1  MEM must hold.
- bus_err  out  1  one-cycle pulse on timeout.
- bus_req  out  1  bus request.
- bus_we, bus_addr, bus_wdata, bus_be  out  1/AW/DW/DW/8  registered copy of the owner's request.
- bus_gnt  in  1  the bus accepts the request this cycle.
- bus_rvalid  in  1  response or write acknowledge.
- bus_rdata  in  DW  response data.

Behaviour:
- Reset (asynchronous, reset_n low): state=IDLE, owner=IF, drop=0, run_cnt=0, to_cnt=0. bus_req, if_valid, mem_valid and bus_err are 0. All data and address outputs are 0.
- States:
  - IDLE: arbitrate. A grant loads the bus_* registers and moves to REQ on the next edge.
  - REQ: bus_req=1. On bus_gnt, move to WAIT and clear to_cnt. bus_* fields stay stable until bus_gnt.
  - WAIT: on bus_rvalid, move to IDLE. Otherwise to_cnt increments; when to_cnt==TIMEOUT, move to IDLE and report an error.
- Arbitration in IDLE:
  - MEM wins if mem_req=1 and (if_req=0 or run_cnt<MAX_MEM_RUN).
  - Otherwise IF wins if if_req=1 and flush=0.
  - A MEM grant with if_req=1 increments run_cnt. Any IF grant, or if_req=0, clears run_cnt.
- Response path:
  - On bus_rvalid in WAIT, the owner's rdata is registered and the owner's valid pulses on the following cycle, coincident with the return to IDLE.
  - mem_rdata is unchanged for stores.
  - Minimum latency from request to valid is 3 cycles: grant in IDLE, REQ with same-cycle bus_gnt, WAIT with same-cycle bus_rvalid, then the valid pulse.
  - The valid pulse cycle is an IDLE cycle, so the requester can present a new request and have it granted the cycle after.
- Flush:
  - flush=1 while owner=IF in REQ or WAIT sets drop. The transaction is not withdrawn.
  - On completion with drop=1: no if_valid, drop is cleared, return to IDLE.
  - flush has no effect on MEM transactions.
  - flush in IDLE blocks an IF grant that cycle only.
- Timeout: bus_err pulses. The owner's valid pulses with rdata=0 unless drop is set. Return to IDLE.
- Stalls (combinational):
  - stall_if = if_req & ~if_valid.
  - stall_mem = mem_req & ~mem_valid.
- Simultaneous events:
  - bus_rvalid and flush in the same WAIT cycle: the response is dropped.
  - bus_gnt and bus_rvalid in the same REQ cycle: bus_rvalid is ignored. The bus protocol guarantees a response only after the grant cycle.
- Reset mid-transaction: returns to IDLE immediately. No valid pulse is issued and the outstanding bus transaction is abandoned.

Test Plan:
- IF only: if_addr=0x100, bus_gnt and bus_rvalid tied high with bus_rdata=0x00A00093 -> if_valid pulses 3 cycles after if_req rises with if_rdata=0x00A00093; stall_if high for exactly 3 cycles.
- Contention: if_req and mem_req (load 0x2000) rise in the same cycle -> MEM is granted first (bus_addr=0x2000), IF is granted after mem_valid; stall_if stays high throughout.
- Starvation guard: mem_req held high continuously with if_req pending, MAX_MEM_RUN=4 -> exactly 4 MEM grants, then 1 IF grant, then MEM again.
- Flush during fetch: flush pulses while in WAIT for IF address 0x104 -> no if_valid; the next fetch of 0x200 returns normally.
- Store: mem_we=1, mem_be=0x3, mem_wdata=0xBEEF -> bus_be=0x3 and bus_wdata=0xBEEF held stable until bus_gnt (bus_gnt delayed 2 cycles); mem_valid pulses once.
- Timeout and reset: bus_rvalid never asserts, TIMEOUT=8 -> bus_err pulses and mem_valid pulses with mem_rdata=0. reset_n dropped while in WAIT -> bus_req=0 in the same cycle.
